aemb2_xwb_arb: RTL and testbench
================================

# aemb2_xwb_arb

Two-master Wishbone arbiter that shares a single external bus (XWB) between the AEMB2 instruction port (IWB) and data port (DWB). It sits between the core's system-control handshake outputs and the external memory/peripheral fabric. It grants one master at a time, forwards address, data and strobes, and routes ack/err back. A watchdog terminates stalled cycles with an error.

## Interface
- AW, 32: address width; byte address, bits [AW-1:2] carried.
- DW, 32: data width.
- TOUT, 15: watchdog limit in cycles without ack (1..255).
- sys_clk_i  in  1  clock; all flops on rising edge.
- sys_rst_i  in  1  reset, asynchronous assert, active-low.
- iwb_adr_i  in  AW-2  instruction address.
- iwb_stb_i  in  1  instruction request.
- iwb_ack_o  out  1  instruction acknowledge.
- iwb_err_o  out  1  instruction error (timeout or slave err).
- iwb_dat_o  out  DW  instruction read data.
- dwb_adr_i  in  AW-2  data address.
- dwb_dat_i  in  DW  data write data.
- dwb_sel_i  in  DW/8  byte selects.
- dwb_cyc_i  in  1  data cycle / bus lock.
- dwb_stb_i  in  1  data request.
- dwb_wre_i  in  1  data write enable.
- dwb_ack_o  out  1  data acknowledge.
- dwb_err_o  out  1  data error.
- dwb_dat_o  out  DW  data read data.
- xwb_adr_o, xwb_dat_o, xwb_sel_o  out  AW-2/DW/DW/8  muxed to slave.
- xwb_cyc_o, xwb_stb_o, xwb_wre_o  out  1  muxed control.
- xwb_dat_i  in  DW  slave read data; xwb_ack_i, xwb_err_i  in  1  slave response.

## Operation
- State register: IDLE, IGNT, DGNT. Reset: IDLE, counter 0, last-grant pointer = IGNT.
- IDLE: all xwb_* outputs 0; ack/err outputs 0. If only iwb_stb_i -> IGNT; if only dwb_stb_i -> DGNT; both -> priority rule (see Configuration).
- IGNT: xwb_adr_o = iwb_adr_i, xwb_cyc_o = xwb_stb_o = iwb_stb_i, xwb_wre_o = 0, xwb_sel_o = all ones, xwb_dat_o = 0.
- DGNT: xwb_adr/dat/sel/wre_o from dwb_*, xwb_cyc_o = dwb_cyc_i | dwb_stb_i, xwb_stb_o = dwb_stb_i.
- Response routing: ack_o = xwb_ack_i & granted & stb_i; err_o = (xwb_err_i | timeout) & granted & stb_i; read data passed to both masters unqualified, valid only with ack.
- Exit IGNT -> IDLE on ack, err, timeout, or iwb_stb_i low.
- Exit DGNT -> IDLE on ack/err/timeout while dwb_cyc_i low, or when both dwb_stb_i and dwb_cyc_i low. With dwb_cyc_i high, DGNT is held (lock) after ack; stb re-asserted under lock continues without re-arbitration.
- Watchdog: 8-bit counter cleared on entering a grant and on every ack; increments each granted cycle with xwb_stb_o high and no ack/err; timeout = counter == TOUT. Counter frozen while stb low under lock.
- Non-granted master sees ack_o = err_o = 0 and simply waits.

## Timing
- Grant registered: request in cycle N (IDLE) -> xwb_stb_o in N+1.
- Ack combinational pass-through: xwb_ack_i in cycle M -> ack_o in M.
- Mandatory one IDLE cycle between grants; back-to-back single accesses from one master: 2 cycles minimum per access.
- Timeout: err_o asserted in the cycle counter == TOUT, i.e. TOUT+1 granted cycles after xwb_stb_o first rises without ack.
- Simultaneous ack and err from slave: err wins, ack_o suppressed.
- Reset mid-cycle: outputs drop to 0 asynchronously; pending master transfer is lost (core is reset with it).

## Configuration
- AEMB2_XWB_ARB_RR_EN defined: round-robin on simultaneous requests; pointer updates on each grant; first contention after reset grants DWB.
- Undefined: fixed priority, DWB always wins contention; pointer logic removed.

## Test plan
- Single IWB read at 0x100, slave acks 2 cycles after stb -> xwb_adr_o = 0x40, iwb_ack_o one cycle, iwb_dat_o = slave data, return to IDLE.
- IWB and DWB request same cycle, RR undefined -> DGNT first, then IGNT after one IDLE; RR defined, three contentions -> D, I, D.
- DWB write with dwb_cyc_i held over two strobes -> IWB request stalls until dwb_cyc_i drops; no IDLE between the two data strobes.
- Slave never acks, TOUT=15 -> err_o exactly 16 cycles after stb, one cycle wide, state IDLE next cycle.
- xwb_err_i and xwb_ack_i same cycle -> err_o = 1, ack_o = 0.
- sys_rst_i low during DGNT -> xwb_cyc_o/stb_o = 0 immediately; after release, state IDLE, counter 0.

Source files
------------

// File: rtl/aemb2_xwb_arb.sv
// Two-master Wishbone arbiter: AEMB2 IWB/DWB onto one XWB, with watchdog.
// Define AEMB2_XWB_ARB_RR_EN for round-robin contention, else DWB wins.
module aemb2_xwb_arb #(
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int TOUT = 15
) (
  input  logic              sys_clk_i,
  input  logic              sys_rst_i,
  input  logic [AW-3:0]     iwb_adr_i,
  input  logic              iwb_stb_i,
  output logic              iwb_ack_o,
  output logic              iwb_err_o,
  output logic [DW-1:0]     iwb_dat_o,
  input  logic [AW-3:0]     dwb_adr_i,
  input  logic [DW-1:0]     dwb_dat_i,
  input  logic [DW/8-1:0]   dwb_sel_i,
  input  logic              dwb_cyc_i,
  input  logic              dwb_stb_i,
  input  logic              dwb_wre_i,
  output logic              dwb_ack_o,
  output logic              dwb_err_o,
  output logic [DW-1:0]     dwb_dat_o,
  output logic [AW-3:0]     xwb_adr_o,
  output logic [DW-1:0]     xwb_dat_o,
  output logic [DW/8-1:0]   xwb_sel_o,
  output logic              xwb_cyc_o,
  output logic              xwb_stb_o,
  output logic              xwb_wre_o,
  input  logic [DW-1:0]     xwb_dat_i,
  input  logic              xwb_ack_i,
  input  logic              xwb_err_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } state_t;

  localparam logic [7:0] TLIM = TOUT[7:0];

  state_t     state;
  logic [7:0] cnt;
  logic       ign;
  logic       dgn;
  logic       tmo;
  logic       err_any;
  logic       ack_ok;
  logic       pick_d;

  assign ign     = (state == IGNT);
  assign dgn     = (state == DGNT);
  assign tmo     = (ign | dgn) && (cnt == TLIM);
  assign err_any = xwb_err_i | tmo;
  assign ack_ok  = xwb_ack_i & ~err_any;

`ifdef AEMB2_XWB_ARB_RR_EN
  state_t ptr;
  assign pick_d = (ptr == IGNT);
`else
  assign pick_d = 1'b1;
`endif

  always_comb begin
    xwb_adr_o = '0;
    xwb_dat_o = '0;
    xwb_sel_o = '0;
    xwb_cyc_o = 1'b0;
    xwb_stb_o = 1'b0;
    xwb_wre_o = 1'b0;
    unique case (1'b1)
      ign: begin
        xwb_adr_o = iwb_adr_i;
        xwb_sel_o = '1;
        xwb_cyc_o = iwb_stb_i;
        xwb_stb_o = iwb_stb_i;
      end
      dgn: begin
        xwb_adr_o = dwb_adr_i;
        xwb_dat_o = dwb_dat_i;
        xwb_sel_o = dwb_sel_i;
        xwb_cyc_o = dwb_cyc_i | dwb_stb_i;
        xwb_stb_o = dwb_stb_i;
        xwb_wre_o = dwb_wre_i;
      end
      default: ;
    endcase
  end

  assign iwb_ack_o = ack_ok  & ign & iwb_stb_i;
  assign iwb_err_o = err_any & ign & iwb_stb_i;
  assign dwb_ack_o = ack_ok  & dgn & dwb_stb_i;
  assign dwb_err_o = err_any & dgn & dwb_stb_i;
  assign iwb_dat_o = xwb_dat_i;
  assign dwb_dat_o = xwb_dat_i;

  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      state <= IDLE;
      cnt   <= 8'd0;
`ifdef AEMB2_XWB_ARB_RR_EN
      ptr   <= IGNT;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= 8'd0;
          if (dwb_stb_i && (!iwb_stb_i || pick_d)) begin
            state <= DGNT;
`ifdef AEMB2_XWB_ARB_RR_EN
            ptr   <= DGNT;
`endif
          end else if (iwb_stb_i) begin
            state <= IGNT;
`ifdef AEMB2_XWB_ARB_RR_EN
            ptr   <= IGNT;
`endif
          end
        end
        IGNT: begin
          if (xwb_ack_i || err_any || !iwb_stb_i) begin
            state <= IDLE;
            cnt   <= 8'd0;
          end else if (xwb_stb_o) begin
            cnt <= cnt + 8'd1;
          end
        end
        DGNT: begin
          // a held dwb_cyc_i locks the bus across strobes
          if (!dwb_cyc_i && (xwb_ack_i || err_any || !dwb_stb_i)) begin
            state <= IDLE;
            cnt   <= 8'd0;
          end else if (xwb_ack_i) begin
            cnt <= 8'd0;
          end else if (xwb_stb_o && !err_any) begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aemb2_xwb_arb.sv
// Directed vector bench for aemb2_xwb_arb.
// Table rows are one clock each; corner cases are hand sequences.
module tb_aemb2_xwb_arb;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int TOUT = 15;

  localparam logic [AW-3:0]   IADR = 30'h40;
  localparam logic [AW-3:0]   DADR = 30'h0123456;
  localparam logic [DW-1:0]   DDAT = 32'hdeadbeef;
  localparam logic [DW/8-1:0] DSEL = 4'h5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [AW-3:0]   iwb_adr;
  logic            iwb_stb;
  logic            iwb_ack;
  logic            iwb_err;
  logic [DW-1:0]   iwb_dat;
  logic [AW-3:0]   dwb_adr;
  logic [DW-1:0]   dwb_dat_w;
  logic [DW/8-1:0] dwb_sel;
  logic            dwb_cyc;
  logic            dwb_stb;
  logic            dwb_wre;
  logic            dwb_ack;
  logic            dwb_err;
  logic [DW-1:0]   dwb_dat_r;
  logic [AW-3:0]   xwb_adr;
  logic [DW-1:0]   xwb_dat_w;
  logic [DW/8-1:0] xwb_sel;
  logic            xwb_cyc;
  logic            xwb_stb;
  logic            xwb_wre;
  logic [DW-1:0]   xwb_dat_r;
  logic            xwb_ack;
  logic            xwb_err;

  always #5 clk = ~clk;

  aemb2_xwb_arb #(.AW(AW), .DW(DW), .TOUT(TOUT)) dut (
    .sys_clk_i (clk),
    .sys_rst_i (rst_n),
    .iwb_adr_i (iwb_adr),
    .iwb_stb_i (iwb_stb),
    .iwb_ack_o (iwb_ack),
    .iwb_err_o (iwb_err),
    .iwb_dat_o (iwb_dat),
    .dwb_adr_i (dwb_adr),
    .dwb_dat_i (dwb_dat_w),
    .dwb_sel_i (dwb_sel),
    .dwb_cyc_i (dwb_cyc),
    .dwb_stb_i (dwb_stb),
    .dwb_wre_i (dwb_wre),
    .dwb_ack_o (dwb_ack),
    .dwb_err_o (dwb_err),
    .dwb_dat_o (dwb_dat_r),
    .xwb_adr_o (xwb_adr),
    .xwb_dat_o (xwb_dat_w),
    .xwb_sel_o (xwb_sel),
    .xwb_cyc_o (xwb_cyc),
    .xwb_stb_o (xwb_stb),
    .xwb_wre_o (xwb_wre),
    .xwb_dat_i (xwb_dat_r),
    .xwb_ack_i (xwb_ack),
    .xwb_err_i (xwb_err)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       istb, dstb, dcyc, ack, err;
    logic [1:0] gnt;
    logic [5:0] out;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [4:0] in, input logic [1:0] g,
                              input logic [5:0] o);
    vec_t v;
    {v.istb, v.dstb, v.dcyc, v.ack, v.err} = in;
    v.gnt = g;
    v.out = o;
    return v;
  endfunction

  function automatic logic [127:0] bus_exp(input logic [1:0] g);
    logic [127:0] r;
    r = '0;
    if (g == 2'd1) r = 128'({IADR, 32'h0, 4'hf, 1'b0});
    if (g == 2'd2) r = 128'({DADR, DDAT, DSEL, 1'b1});
    return r;
  endfunction

  task automatic tmo_run(input bit d, input string nm);
    for (int k = 1; k <= TOUT + 1; k++) begin
      @(negedge clk);
      #1;
      chk({nm, "_stb"}, 128'(xwb_stb), 128'(1'b1));
      chk({nm, "_err"}, 128'(d ? dwb_err : iwb_err), 128'(k == TOUT + 1));
    end
    @(negedge clk);
    iwb_stb = 1'b0;
    dwb_stb = 1'b0;
    #1;
    chk({nm, "_after"}, 128'({xwb_stb, iwb_err, dwb_err}), 128'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [2:0] rr_exp;
    iwb_adr   = IADR;
    dwb_adr   = DADR;
    dwb_dat_w = DDAT;
    dwb_sel   = DSEL;
    dwb_wre   = 1'b1;
    iwb_stb   = 1'b1;
    dwb_stb   = 1'b1;
    dwb_cyc   = 1'b1;
    xwb_ack   = 1'b0;
    xwb_err   = 1'b0;
    xwb_dat_r = 32'h0;

    repeat (2) @(negedge clk);
    #1;
    chk("reset_ctl", 128'({xwb_stb, xwb_cyc, iwb_ack, iwb_err, dwb_ack, dwb_err}),
        128'(0));
    chk("reset_bus", 128'({xwb_adr, xwb_dat_w, xwb_sel, xwb_wre}), 128'(0));
    iwb_stb = 1'b0;
    dwb_stb = 1'b0;
    dwb_cyc = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // three back-to-back contentions right after reset
`ifdef AEMB2_XWB_ARB_RR_EN
    rr_exp = 3'b101;
`else
    rr_exp = 3'b111;
`endif
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      iwb_stb = 1'b1;
      dwb_stb = 1'b1;
      xwb_ack = 1'b0;
      #1;
      chk("arb_idle", 128'(xwb_stb), 128'(1'b0));
      @(negedge clk);
      xwb_ack = 1'b1;
      #1;
      chk("arb_grant", 128'({dwb_ack, iwb_ack}),
          128'(rr_exp[n] ? 2'b10 : 2'b01));
    end
    @(negedge clk);
    iwb_stb = 1'b0;
    dwb_stb = 1'b0;
    xwb_ack = 1'b0;

    // in: istb dstb dcyc ack err | gnt | xstb xcyc iack ierr dack derr
    tbl.push_back(mk(5'b10000, 2'd0, 6'b000000));
    tbl.push_back(mk(5'b10000, 2'd1, 6'b110000));
    tbl.push_back(mk(5'b10000, 2'd1, 6'b110000));
    tbl.push_back(mk(5'b10010, 2'd1, 6'b111000));
    tbl.push_back(mk(5'b00000, 2'd0, 6'b000000));
    tbl.push_back(mk(5'b11000, 2'd0, 6'b000000));
    tbl.push_back(mk(5'b11000, 2'd2, 6'b110000));
    tbl.push_back(mk(5'b11010, 2'd2, 6'b110010));
    tbl.push_back(mk(5'b10000, 2'd0, 6'b000000));
    tbl.push_back(mk(5'b10000, 2'd1, 6'b110000));
    tbl.push_back(mk(5'b10010, 2'd1, 6'b111000));
    tbl.push_back(mk(5'b00000, 2'd0, 6'b000000));
    tbl.push_back(mk(5'b01100, 2'd0, 6'b000000));
    tbl.push_back(mk(5'b11100, 2'd2, 6'b110000));
    tbl.push_back(mk(5'b11110, 2'd2, 6'b110010));
    tbl.push_back(mk(5'b10100, 2'd2, 6'b010000));
    tbl.push_back(mk(5'b11110, 2'd2, 6'b110010));
    tbl.push_back(mk(5'b10000, 2'd2, 6'b000000));
    tbl.push_back(mk(5'b10000, 2'd0, 6'b000000));
    tbl.push_back(mk(5'b10000, 2'd1, 6'b110000));
    tbl.push_back(mk(5'b10011, 2'd1, 6'b110100));
    tbl.push_back(mk(5'b00000, 2'd0, 6'b000000));
    tbl.push_back(mk(5'b01000, 2'd0, 6'b000000));
    tbl.push_back(mk(5'b01000, 2'd2, 6'b110000));
    tbl.push_back(mk(5'b01001, 2'd2, 6'b110001));
    tbl.push_back(mk(5'b00000, 2'd0, 6'b000000));

    foreach (tbl[i]) begin
      @(negedge clk);
      iwb_stb   = tbl[i].istb;
      dwb_stb   = tbl[i].dstb;
      dwb_cyc   = tbl[i].dcyc;
      xwb_ack   = tbl[i].ack;
      xwb_err   = tbl[i].err;
      xwb_dat_r = 32'ha5000000 | 32'(i);
      #1;
      chk($sformatf("vec%0d_ctl", i),
          128'({xwb_stb, xwb_cyc, iwb_ack, iwb_err, dwb_ack, dwb_err}),
          128'(tbl[i].out));
      chk($sformatf("vec%0d_bus", i),
          128'({xwb_adr, xwb_dat_w, xwb_sel, xwb_wre}), bus_exp(tbl[i].gnt));
      chk($sformatf("vec%0d_rdat", i), 128'({iwb_dat, dwb_dat_r}),
          128'({2{32'ha5000000 | 32'(i)}}));
    end

    // instruction fetch that the slave never acknowledges
    @(negedge clk);
    iwb_stb = 1'b1;
    #1;
    chk("itmo_idle", 128'(xwb_stb), 128'(1'b0));
    tmo_run(1'b0, "itmo");

    // reset in the middle of a locked data cycle
    @(negedge clk);
    dwb_stb = 1'b1;
    dwb_cyc = 1'b1;
    #1;
    chk("rst_pre_idle", 128'(xwb_stb), 128'(1'b0));
    @(negedge clk);
    #1;
    chk("rst_pre_dgnt", 128'({xwb_cyc, xwb_stb}), 128'(2'b11));
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async", 128'({xwb_cyc, xwb_stb, dwb_ack, dwb_err}), 128'(0));
    dwb_cyc = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_post_idle", 128'({xwb_cyc, xwb_stb}), 128'(0));
    tmo_run(1'b1, "dtmo");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
